// File: rtl/aes_p2s_stream_ctrl.sv
// aes_p2s_stream_ctrl: sequences a 4-byte parallel-to-serial shifter so a 32*NCOL-bit block leaves column-major as a byte stream
module aes_p2s_stream_ctrl #(
    parameter int NCOL = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [32*NCOL-1:0]  blk_data,
    input  logic                blk_valid,
    output logic                blk_ready,
    input  logic                col_hold,
    output logic                p2s_load,
    output logic [7:0]          p2s_b0,
    output logic [7:0]          p2s_b1,
    output logic [7:0]          p2s_b2,
    output logic [7:0]          p2s_b3,
    output logic                out_valid,
    output logic                out_first,
    output logic                out_last,
    output logic                busy
);
    localparam int CW = NCOL > 1 ? $clog2(NCOL) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t        state;
    logic [1:0]    ph;
    logic [CW-1:0] col;
    logic [31:0]   blk [NCOL];
    logic [31:0]   word;
    logic          sending;
    logic          acc;

    assign sending = state == SEND;
    assign word    = blk[col];

    // column gating, stream flags and the handshake; hold only matters at a column boundary
    always_comb begin
        p2s_load  = sending && ph == 2'd0 && !col_hold;
        out_valid = sending && (ph != 2'd0 || !col_hold);
        out_first = out_valid && ph == 2'd0 && col == '0;
        out_last  = out_valid && ph == 2'd3 && col == CW'(NCOL - 1);
        blk_ready = !sending || out_last;
        busy      = sending;
        acc       = blk_valid && blk_ready;
        {p2s_b0, p2s_b1, p2s_b2, p2s_b3} = sending ? word : 32'd0;
    end

    // FSM, phase/column counters and block capture (column 0 is the MSB word)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ph    <= 2'd0;
            col   <= '0;
            for (int i = 0; i < NCOL; i++) blk[i] <= 32'd0;
        end else if (acc) begin
            state <= SEND;
            ph    <= 2'd0;
            col   <= '0;
            for (int i = 0; i < NCOL; i++) blk[i] <= blk_data[32*(NCOL-i)-1 -: 32];
        end else if (out_last) begin
            state <= IDLE;
            ph    <= 2'd0;
            col   <= '0;
        end else if (out_valid) begin
            ph <= ph + 2'd1;
            if (ph == 2'd3) col <= col + 1'b1;
        end
    end
endmodule

// File: tb/tb_aes_p2s_stream_ctrl.sv
// tb_aes_p2s_stream_ctrl: scoreboard bench with a behavioural shifter model
module tb_aes_p2s_stream_ctrl;
    localparam int NCOL = 4;
    localparam logic [127:0] BLK_A = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] BLK_B = 128'hFFEEDDCCBBAA99887766554433221100;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] blk_data = '0;
    logic         blk_valid = 1'b0;
    logic         col_hold = 1'b0;
    logic         blk_ready, p2s_load, out_valid, out_first, out_last, busy;
    logic [7:0]   p2s_b0, p2s_b1, p2s_b2, p2s_b3;

    aes_p2s_stream_ctrl #(.NCOL(NCOL)) dut (
        .clk(clk), .rst(rst), .blk_data(blk_data), .blk_valid(blk_valid),
        .blk_ready(blk_ready), .col_hold(col_hold), .p2s_load(p2s_load),
        .p2s_b0(p2s_b0), .p2s_b1(p2s_b1), .p2s_b2(p2s_b2), .p2s_b3(p2s_b3),
        .out_valid(out_valid), .out_first(out_first), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [7:0] b;
        logic       f;
        logic       l;
    } exp_t;

    exp_t q[$];
    int   load_t[$];
    logic [23:0] sh;
    int   sh_n = 0;
    int   cyc = 0;
    int   t_acc = 0;
    int   t_last = 0;
    int   n_gap = 0;
    int   n_nready = 0;

    // shifter model plus scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        logic [7:0] byt;
        exp_t e;
        byt = 8'h00;
        cyc++;
        if (rst) begin
            sh_n = 0;
            q.delete();
        end else begin
            chk("valid_vs_shifter", out_valid, p2s_load || sh_n > 0);
            if (p2s_load) begin
                byt = p2s_b0;
                sh = {p2s_b1, p2s_b2, p2s_b3};
                sh_n = 3;
                load_t.push_back(cyc - t_acc);
            end else if (sh_n > 0) begin
                byt = sh[23:16];
                sh = sh << 8;
                sh_n--;
            end
            if (out_valid) begin
                if (q.size() == 0) chk("unexpected_byte", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("byte", byt, e.b);
                    chk("first", out_first, e.f);
                    chk("last", out_last, e.l);
                end
                if (out_last) t_last = cyc;
            end else begin
                if (out_first || out_last) chk("flag_without_valid", {out_first, out_last}, 0);
                if (busy) n_gap++;
            end
            if (busy && !blk_ready) n_nready++;
            if (blk_valid && blk_ready) begin
                t_acc = cyc;
                for (int k = 0; k < 16; k++) begin
                    e.b = blk_data[127-8*k -: 8];
                    e.f = k == 0;
                    e.l = k == 15;
                    q.push_back(e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        load_t.delete();
        n_gap = 0;
        n_nready = 0;
    endtask

    task automatic send(input logic [127:0] d);
        blk_data = d;
        blk_valid = 1'b1;
        step();
        blk_valid = 1'b0;
    endtask

    task automatic wait_idle(input bit scramble);
        bit done;
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            if (q.size() == 0 && !busy) done = 1;
            else begin
                if (scramble) blk_data = {$urandom, $urandom, $urandom, $urandom};
                step();
            end
        end
        chk("drain_timeout", done, 1);
    endtask

    task automatic chk_loads(input string tag, input int a, input int b, input int c, input int d);
        chk({tag, "_nload"}, load_t.size(), 4);
        if (load_t.size() == 4) begin
            chk({tag, "_load0"}, load_t[0], a);
            chk({tag, "_load1"}, load_t[1], b);
            chk({tag, "_load2"}, load_t[2], c);
            chk({tag, "_load3"}, load_t[3], d);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ready"}, blk_ready, 1);
        chk({tag, "_ctl"}, {p2s_load, out_valid, out_first, out_last, busy}, 0);
        chk({tag, "_bytes"}, {p2s_b0, p2s_b1, p2s_b2, p2s_b3}, 0);
    endtask

    initial begin
        int t1;
        #1;
        chk_reset_outs("reset");
        step();
        step();
        rst = 1'b0;
        step();

        clear_stats();
        send(BLK_A);
        wait_idle(0);
        chk("single_latency", t_last - t_acc, 16);
        chk("single_gaps", n_gap, 0);
        chk("single_not_ready", n_nready, 15);
        chk_loads("single", 1, 5, 9, 13);

        clear_stats();
        blk_data = BLK_A;
        blk_valid = 1'b1;
        step();
        t1 = t_acc;
        blk_data = BLK_B;
        repeat (16) step();
        blk_valid = 1'b0;
        chk("b2b_second_hs", t_acc - t1, 16);
        wait_idle(0);
        chk("b2b_total", t_last - t1, 32);
        chk("b2b_gaps", n_gap, 0);

        clear_stats();
        send(BLK_A);
        repeat (8) step();
        col_hold = 1'b1;
        repeat (3) step();
        col_hold = 1'b0;
        wait_idle(0);
        chk("hold_gaps", n_gap, 3);
        chk("hold_latency", t_last - t_acc, 19);
        chk_loads("hold", 1, 5, 12, 16);

        clear_stats();
        send(BLK_B);
        for (int k = 1; k <= 16; k++) begin
            col_hold = (k % 4) != 1;
            step();
        end
        col_hold = 1'b0;
        wait_idle(0);
        chk("midhold_gaps", n_gap, 0);
        chk("midhold_latency", t_last - t_acc, 16);

        send(BLK_A);
        repeat (6) step();
        #1;
        rst = 1'b1;
        #1;
        chk_reset_outs("async_rst");
        step();
        rst = 1'b0;
        #1;
        chk("post_rst_ready", blk_ready, 1);
        clear_stats();
        send(BLK_B);
        wait_idle(0);
        chk("post_rst_latency", t_last - t_acc, 16);
        chk_loads("post_rst", 1, 5, 9, 13);

        send(BLK_A);
        wait_idle(1);
        chk("scramble_idle", {busy, blk_ready}, 2'b01);

        repeat (2) step();
        chk("final_queue", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
